// File: rtl/alu_arbiter_if.sv
// Shared types and the bundle of requester/ALU signals around alu_arbiter.
// master = requesters plus ALU (the environment), slave = the arbiter itself.
package alu_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB,
    ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;
endpackage

interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic   req0, req1, lock0, lock1;
  aluop_t op0, op1;
  word_t  a0, b0, a1, b1;
  logic   gnt0, gnt1, rvalid0, rvalid1;
  word_t  rdata;
  logic   rnf, rzf, rvf;
  logic [1:0] owner;
  aluop_t alu_op;
  word_t  alu_a, alu_b, alu_out;
  logic   alu_nf, alu_zf, alu_vf;

  modport master (
    output req0, req1, lock0, lock1, op0, op1, a0, b0, a1, b1,
    output alu_out, alu_nf, alu_zf, alu_vf,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, rnf, rzf, rvf, owner,
    input  alu_op, alu_a, alu_b
  );

  modport slave (
    input  req0, req1, lock0, lock1, op0, op1, a0, b0, a1, b1,
    input  alu_out, alu_nf, alu_zf, alu_vf,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, rnf, rzf, rvf, owner,
    output alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter for one shared combinational ALU, with owner lock
// and a one-cycle registered result path back to the granted requester.
module alu_arbiter #(
  parameter logic PRIO_RST = 1'b0
) (
  input logic          CLK,
  input logic          nRST,
  alu_arbiter_if.slave bus
);
  import alu_arbiter_pkg::*;

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  state_t state_q, state_d;
  logic   last_q;
  word_t  rdata_q;
  logic   rnf_q, rzf_q, rvf_q;
  logic   rvalid0_q, rvalid1_q;
  logic   gnt0, gnt1;
  aluop_t alu_op;
  word_t  alu_a, alu_b;

  // Grant is combinational and forced low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (nRST) begin
      case (state_q)
        IDLE: begin
          if (bus.req0 && bus.req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
        end
        LOCK0:   gnt0 = bus.req0;
        LOCK1:   gnt1 = bus.req1;
        default: ;
      endcase
    end
  end

  // Inside a lock the owner only leaves once lock drops: either with its final
  // granted op or by abandoning (no req, no lock) -- both reduce to !lock.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt0 && bus.lock0)      state_d = LOCK0;
        else if (gnt1 && bus.lock1) state_d = LOCK1;
      end
      LOCK0:   if (!bus.lock0) state_d = IDLE;
      LOCK1:   if (!bus.lock1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (gnt0) begin
      alu_op = bus.op0;
      alu_a  = bus.a0;
      alu_b  = bus.b0;
    end else if (gnt1) begin
      alu_op = bus.op1;
      alu_a  = bus.a1;
      alu_b  = bus.b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      last_q    <= ~PRIO_RST;
      rdata_q   <= '0;
      rnf_q     <= 1'b0;
      rzf_q     <= 1'b0;
      rvf_q     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      if (gnt0 || gnt1) begin
        last_q  <= gnt1;
        rdata_q <= bus.alu_out;
        rnf_q   <= bus.alu_nf;
        rzf_q   <= bus.alu_zf;
        rvf_q   <= bus.alu_vf;
      end
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = rdata_q;
  assign bus.rnf     = rnf_q;
  assign bus.rzf     = rzf_q;
  assign bus.rvf     = rvf_q;
  assign bus.owner   = state_q;
  assign bus.alu_op  = alu_op;
  assign bus.alu_a   = alu_a;
  assign bus.alu_b   = alu_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small ALU answers the arbiter's mux and
// each step checks grants, then the registered result one cycle later.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 CLK = ~CLK;

  alu_arbiter_if bus();

  alu_arbiter #(.PRIO_RST(1'b0)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // Environment ALU.
  always_comb begin
    bus.alu_vf = 1'b0;
    case (bus.alu_op)
      ALU_ADD: begin
        bus.alu_out = bus.alu_a + bus.alu_b;
        bus.alu_vf  = (bus.alu_a[31] == bus.alu_b[31]) && (bus.alu_out[31] != bus.alu_a[31]);
      end
      ALU_SUB: begin
        bus.alu_out = bus.alu_a - bus.alu_b;
        bus.alu_vf  = (bus.alu_a[31] != bus.alu_b[31]) && (bus.alu_out[31] != bus.alu_a[31]);
      end
      ALU_AND: bus.alu_out = bus.alu_a & bus.alu_b;
      ALU_OR:  bus.alu_out = bus.alu_a | bus.alu_b;
      ALU_XOR: bus.alu_out = bus.alu_a ^ bus.alu_b;
      default: bus.alu_out = 32'h0BAD_C0DE;
    endcase
    bus.alu_nf = bus.alu_out[31];
    bus.alu_zf = (bus.alu_out == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drv0(input logic r, input logic l, input aluop_t op, input word_t a, input word_t b);
    bus.req0 = r; bus.lock0 = l; bus.op0 = op; bus.a0 = a; bus.b0 = b;
  endtask

  task automatic drv1(input logic r, input logic l, input aluop_t op, input word_t a, input word_t b);
    bus.req1 = r; bus.lock1 = l; bus.op1 = op; bus.a1 = a; bus.b1 = b;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset held with both requesters active
    nRST = 1'b0;
    drv0(1'b1, 1'b0, ALU_ADD, 32'd5, 32'd7);
    drv1(1'b1, 1'b0, ALU_SUB, 32'd10, 32'd4);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rvalid1", bus.rvalid1, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_flags", {bus.rnf, bus.rzf, bus.rvf}, 0);
    nRST = 1'b1;
    settle();

    // First contended cycle: port 0 wins with PRIO_RST = 0
    chk("A_gnt0", bus.gnt0, 1);
    chk("A_gnt1", bus.gnt1, 0);
    chk("A_alu_a", bus.alu_a, 5);
    cyc();
    chk("A_rvalid0", bus.rvalid0, 1);
    chk("A_rvalid1", bus.rvalid1, 0);
    chk("A_rdata", bus.rdata, 12);
    chk("A_rzf", bus.rzf, 0);

    // Round-robin: port 1 next, then 0, then 1
    drv0(1'b1, 1'b0, ALU_SUB, 32'd3, 32'd3);
    settle();
    chk("B_gnt0", bus.gnt0, 0);
    chk("B_gnt1", bus.gnt1, 1);
    cyc();
    chk("B_rvalid1", bus.rvalid1, 1);
    chk("B_rvalid0", bus.rvalid0, 0);
    chk("B_rdata", bus.rdata, 6);
    drv1(1'b1, 1'b0, ALU_OR, 32'h0F0, 32'h00F);
    settle();
    chk("C_gnt0", bus.gnt0, 1);
    chk("C_gnt1", bus.gnt1, 0);
    cyc();
    chk("C_rvalid0", bus.rvalid0, 1);
    chk("C_rdata", bus.rdata, 0);
    chk("C_rzf", bus.rzf, 1);
    drv0(1'b1, 1'b0, ALU_AND, 32'hFF0F, 32'h0FF0);
    settle();
    chk("D_gnt1", bus.gnt1, 1);
    chk("D_gnt0", bus.gnt0, 0);
    cyc();
    chk("D_rvalid1", bus.rvalid1, 1);
    chk("D_rdata", bus.rdata, 32'h0FF);
    chk("D_rzf", bus.rzf, 0);

    // Lone request on port 1 right after it was last granted; overflow passthrough
    drv0(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    drv1(1'b1, 1'b0, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    settle();
    chk("E_gnt1", bus.gnt1, 1);
    chk("E_alu_b", bus.alu_b, 1);
    cyc();
    chk("E_rdata", bus.rdata, 32'h8000_0000);
    chk("E_rnf", bus.rnf, 1);
    chk("E_rvf", bus.rvf, 1);
    chk("E_rzf", bus.rzf, 0);

    // Single request on port 0, then port 1 alone so that last = 1
    drv1(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    drv0(1'b1, 1'b0, ALU_ADD, 32'd5, 32'd7);
    settle();
    chk("F_gnt0", bus.gnt0, 1);
    cyc();
    chk("F_rvalid0", bus.rvalid0, 1);
    chk("F_rdata", bus.rdata, 12);
    chk("F_rvf", bus.rvf, 0);
    drv0(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    drv1(1'b1, 1'b0, ALU_ADD, 32'd1, 32'd1);
    settle();
    chk("F2_gnt1", bus.gnt1, 1);
    cyc();
    chk("F2_rdata", bus.rdata, 2);

    // Lock hold: port 0 keeps the ALU for 3 cycles, port 1 keeps requesting
    drv1(1'b1, 1'b0, ALU_XOR, 32'hFF, 32'h0F);
    drv0(1'b1, 1'b1, ALU_ADD, 32'd1, 32'd2);
    settle();
    chk("G1_gnt0", bus.gnt0, 1);
    chk("G1_gnt1", bus.gnt1, 0);
    cyc();
    chk("G1_owner", bus.owner, 1);
    chk("G1_rdata", bus.rdata, 3);
    drv0(1'b1, 1'b1, ALU_ADD, 32'd3, 32'd4);
    bus.lock1 = 1'b1;
    settle();
    chk("G2_gnt0", bus.gnt0, 1);
    chk("G2_gnt1", bus.gnt1, 0);
    cyc();
    chk("G2_owner", bus.owner, 1);
    chk("G2_rdata", bus.rdata, 7);
    drv0(1'b1, 1'b1, ALU_ADD, 32'd10, 32'd20);
    settle();
    chk("G3_gnt0", bus.gnt0, 1);
    chk("G3_gnt1", bus.gnt1, 0);
    cyc();
    chk("G3_owner", bus.owner, 1);
    chk("G3_rvalid1", bus.rvalid1, 0);
    drv0(1'b1, 1'b0, ALU_ADD, 32'd100, 32'd1);
    settle();
    chk("G4_gnt0", bus.gnt0, 1);
    chk("G4_gnt1", bus.gnt1, 0);
    cyc();
    chk("G4_owner", bus.owner, 0);
    chk("G4_rdata", bus.rdata, 101);
    drv0(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    settle();
    chk("G5_gnt1", bus.gnt1, 1);
    chk("G5_alu_a", bus.alu_a, 32'hFF);
    cyc();
    chk("G5_owner", bus.owner, 2);
    chk("G5_rvalid1", bus.rvalid1, 1);
    chk("G5_rdata", bus.rdata, 32'hF0);

    // Abandon in LOCK1 while port 0 waits
    drv1(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    drv0(1'b1, 1'b0, ALU_ADD, 32'd2, 32'd2);
    settle();
    chk("H_gnt0", bus.gnt0, 0);
    cyc();
    chk("H_owner", bus.owner, 0);
    chk("H_rvalid1", bus.rvalid1, 0);
    chk("H_rvalid0", bus.rvalid0, 0);
    chk("H_rdata_hold", bus.rdata, 32'hF0);
    settle();
    chk("H2_gnt0", bus.gnt0, 1);
    cyc();
    chk("H2_rvalid0", bus.rvalid0, 1);
    chk("H2_rdata", bus.rdata, 4);

    // lock without req in IDLE has no effect
    drv0(1'b0, 1'b1, ALU_ADD, 32'd0, 32'd0);
    settle();
    chk("I_gnt0", bus.gnt0, 0);
    cyc();
    chk("I_owner", bus.owner, 0);
    chk("I_rvalid0", bus.rvalid0, 0);
    chk("I_rdata_hold", bus.rdata, 4);

    // Reset mid-lock with rvalid1 high
    drv0(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    drv1(1'b1, 1'b1, ALU_ADD, 32'd9, 32'd9);
    cyc();
    chk("J_owner", bus.owner, 2);
    chk("J_rvalid1", bus.rvalid1, 1);
    chk("J_rdata", bus.rdata, 18);
    nRST = 1'b0;
    settle();
    chk("J_rst_owner", bus.owner, 0);
    chk("J_rst_rvalid1", bus.rvalid1, 0);
    chk("J_rst_rdata", bus.rdata, 0);
    chk("J_rst_gnt1", bus.gnt1, 0);
    cyc();
    nRST = 1'b1;
    drv1(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    cyc();
    chk("J_post_rvalid1", bus.rvalid1, 0);
    chk("J_post_rdata", bus.rdata, 0);
    chk("J_post_owner", bus.owner, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter sharing the single combinational ALU between two requesters, e.g. the execute stage (port 0) and an auxiliary multi-cycle unit such as an iterative multiplier/divider (port 1). It grants one requester per cycle, round-robin on contention, and supports a lock so one owner can issue back-to-back dependent operations uninterrupted. It routes the granted operands to the ALU and registers the result and flags back to the winner one cycle later.

## Interface

Parameters:
- PRIO_RST, default 0: requester that wins the first contended cycle after reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- req0, req1  in  1  requester i wants the ALU this cycle; held until granted.
- lock0, lock1  in  1  requester i keeps ownership after the current grant.
- op0, op1  in  aluop_t  operation for requester i.
- a0, b0, a1, b1  in  word_t  operands for requester i.
- gnt0, gnt1  out  1  combinational grant, same cycle as the request; never both high.
- rvalid0, rvalid1  out  1  one-cycle pulse, cycle after gnt_i: result belongs to i.
- rdata  out  word_t  registered ALU result of the last grant.
- rnf, rzf, rvf  out  1  registered negative, zero and overflow flags of the last grant.
- owner  out  2  debug: 0 = IDLE, 1 = LOCK0, 2 = LOCK1.
- alu_op  out  aluop_t  to ALU.
- alu_a, alu_b  out  word_t  to ALU.
- alu_out  in  word_t  from ALU.
- alu_nf, alu_zf, alu_vf  in  1  from ALU.

## Operation

- State registers: `state` ∈ {IDLE, LOCK0, LOCK1}; `last` (1 bit, last granted port); result/flag registers; rvalid0/1.
- Grant in IDLE:
  - Only req_i high: grant i.
  - Both high: grant the port != `last`.
- Grant in LOCK_i:
  - Only requester i can be granted; req of the other port is ignored (gnt low) regardless of `last`.
- Transitions:
  - IDLE → LOCK_i when gnt_i && lock_i.
  - LOCK_i → IDLE when gnt_i && !lock_i; that is the final locked op.
  - LOCK_i → IDLE when !req_i && !lock_i, meaning the owner abandoned.
  - LOCK_i stays when !req_i && lock_i; the owner may idle while holding.
- `last` updates to i on every gnt_i, including grants inside LOCK_i.
- ALU muxing:
  - gnt_i high: alu_op/alu_a/alu_b = op_i/a_i/b_i.
  - No grant: drive ALU_ADD, 0, 0.
- Result capture:
  - On any grant cycle: rdata ← alu_out, rnf/rzf/rvf ← alu_nf/alu_zf/alu_vf, rvalid_i ← 1, other rvalid ← 0.
  - No grant: rvalid0/1 ← 0; rdata and flags hold their previous values.
- Width and arithmetic: pass-through only, no width changes. All arithmetic semantics, including signed overflow and the default 32'hBAD_C0DE for illegal ops, come from the ALU.
- owner = 0/1/2 encodes state directly.

## Timing

- Reset (nRST low, asynchronous):
  - state = IDLE, last = ~PRIO_RST.
  - rdata = 0, rnf = rzf = rvf = 0, rvalid0 = rvalid1 = 0, owner = 0.
  - gnt reflects inputs combinationally even in reset: gnt_i = 0 while nRST is low.
- Grant latency 0 cycles; result latency 1 cycle (rvalid_i and rdata valid the cycle after gnt_i). Throughput one op per cycle.
- Handshake:
  - The requester holds req_i, op_i, a_i, b_i stable until it sees gnt_i high at a clock edge.
  - It may drop or change them the next cycle.
  - It may re-request immediately; a locked owner gets back-to-back grants every cycle.
- Contended requests from the losing port are never dropped; they are served the next non-locked cycle. Worst-case wait without locks is 1 cycle.
- Reset asserted mid-lock or mid-result: state, rvalid and result clear immediately; no pending result is delivered after reset release.
- lock_i without req_i in IDLE has no effect.
- lock of the non-owner in LOCK_i is ignored.

## Test plan

- Reset values: hold nRST low with req0 = req1 = 1 → gnt0 = gnt1 = 0, rvalid = 0, rdata = 0, owner = 0. After release with PRIO_RST = 0, the first contended cycle gives gnt0 = 1.
- Single request: req0 = 1, op0 = ALU_ADD, a0 = 5, b0 = 7 → gnt0 = 1 the same cycle. Next cycle rvalid0 = 1, rvalid1 = 0, rdata = 12, rzf = 0.
- Round-robin: both req high for 4 cycles with distinct ops → grants alternate 0, 1, 0, 1. rvalid pulses follow one cycle behind with matching rdata. ALU_SUB of 3 - 3 yields rzf = 1.
- Lock hold:
  - req0 = lock0 = 1 for 3 cycles while req1 = 1 → gnt0 on all 3 cycles, gnt1 = 0, owner = 1.
  - Cycle 4: lock0 = 0 with req0 = 1 → final gnt0. Cycle 5: gnt1 = 1, owner = 0.
- Overflow passthrough: port1 ALU_ADD with 32'h7FFFFFFF + 1 → rdata = 32'h80000000, rnf = 1, rvf = 1.
- Abandon and reset mid-lock:
  - In LOCK1, drop req1 and lock1 → owner returns to 0 next cycle and a pending req0 is granted.
  - Separately, assert nRST low while in LOCK1 with rvalid1 high → all outputs zero immediately.
